// File: rtl/avalon_pixel_slave.sv
// avalon_pixel_slave: Avalon-MM pixel store slave with pipelined reads and posted writes.
// Reads return after READ_LATENCY cycles. At most MAX_PENDING reads can be in flight.
// Optional macro AVALON_PIXEL_SLAVE_STALL_EN adds LFSR-driven random wait states.
module avalon_pixel_slave #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned MAX_PENDING  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic [3:0]        slave_byteenable,
  output logic              slave_waitrequest,
  output logic [31:0]       slave_readdata,
  output logic              slave_readdatavalid,
  output logic              protocol_err
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LAT    = READ_LATENCY;
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  logic [31:0]       mem [DEPTH];
  logic [LAT-1:0]    pipe_valid;
  logic [31:0]       pipe_data [LAT];
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_next;
  logic              read_accept;
  logic              write_accept;
  logic              stall_next;
  logic              wait_next;
  logic              err_next;

  // Retiring stage of the delay line drives the read response directly.
  assign slave_readdatavalid = pipe_valid[LAT-1];
  assign slave_readdata      = pipe_data[LAT-1];

`ifdef AVALON_PIXEL_SLAVE_STALL_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;

  // Fibonacci LFSR, taps 8,6,5,4; stall next cycle when the low two bits are zero.
  always_comb begin
    lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    stall_next = (lfsr_next[1:0] == 2'b00);
  end

  // LFSR state register, free-running every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= lfsr_next;
    end
  end
`else
  assign stall_next = 1'b0;
`endif

  // Handshake decode and next-state for pending count, waitrequest and error flag.
  always_comb begin
    read_accept  = 1'b0;
    write_accept = 1'b0;
    pending_next = pending;
    wait_next    = 1'b0;
    err_next     = protocol_err;

    read_accept  = slave_read & ~slave_write & ~slave_waitrequest;
    write_accept = slave_write & ~slave_waitrequest;
    pending_next = pending + PEND_W'(read_accept) - PEND_W'(slave_readdatavalid);
    // Waitrequest is registered so it equals the decode of the state it is presented with.
    wait_next    = (pending_next == PEND_W'(MAX_PENDING)) | stall_next;
    err_next     = protocol_err | (slave_read & slave_write);
  end

  // Control state: pending counter, waitrequest and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending           <= '0;
      slave_waitrequest <= 1'b0;
      protocol_err      <= 1'b0;
    end else begin
      pending           <= pending_next;
      slave_waitrequest <= wait_next;
      protocol_err      <= err_next;
    end
  end

  // Byte-masked write port; memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (write_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (slave_byteenable[i]) begin
          mem[slave_address][8*i +: 8] <= slave_writedata[8*i +: 8];
        end
      end
    end
  end

  // Read delay line; data stages only advance with a valid word so readdata holds between returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        pipe_data[k] <= 32'h0;
      end
    end else begin
      pipe_valid[0] <= read_accept;
      if (read_accept) begin
        pipe_data[0] <= mem[slave_address];
      end
      for (int k = 1; k < int'(LAT); k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        if (pipe_valid[k-1]) begin
          pipe_data[k] <= pipe_data[k-1];
        end
      end
    end
  end

endmodule

// File: doc/avalon_pixel_slave.md
# avalon_pixel_slave

Avalon-MM memory-mapped slave that answers the cartoonifier's master port: it accepts pipelined reads and posted writes, stores pixel words in an internal array, and returns read data after a fixed latency with `slave_readdatavalid`. It stands in for the frame-buffer memory in block and system simulation. It also serves as the on-chip scratch store for small test images.

## Interface
- `ADDR_W`, 12: word-address width; array depth is 2**ADDR_W 32-bit words.
- `READ_LATENCY`, 3: cycles from read acceptance to `slave_readdatavalid`, legal range 1..8.
- `MAX_PENDING`, 2: maximum accepted reads not yet returned, legal range 1..READ_LATENCY.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `slave_address` in ADDR_W: word address.
- `slave_read` in 1: read request.
- `slave_write` in 1: write request.
- `slave_writedata` in 32: write data, {8'h00, R, G, B} pixel packing.
- `slave_byteenable` in 4: per-byte write enable; bit i covers bits [8i+7:8i].
- `slave_waitrequest` out 1: request not accepted this cycle.
- `slave_readdata` out 32: read data, meaningful only while valid is high.
- `slave_readdatavalid` out 1: one-cycle pulse per returned read.
- `protocol_err` out 1: sticky flag, set when read and write are asserted together.

## Operation
- Acceptance: a read is accepted on a cycle with `slave_read & ~slave_write & ~slave_waitrequest`. A write is accepted on a cycle with `slave_write & ~slave_waitrequest`.
- Write: bytes with `slave_byteenable` set are stored at the rising edge of the accept cycle. Other bytes are unchanged. Byteenable 4'b0000 writes nothing.
- Read: the array word is sampled at the accept edge and enters a READ_LATENCY-deep delay line of {valid, data}.
  - The word carries the value from before any write accepted in the same cycle. A read accepted at least one cycle after a write returns the new data.
- Read and write together: the write is performed, the read is dropped with no return, and `protocol_err` is set to 1 until `rst`.
- Pending counter (0..MAX_PENDING): `pending_next = pending + read_accept - readdatavalid`.
- Waitrequest: `slave_waitrequest = (pending == MAX_PENDING) | stall`, decoded from registered state only.
  - When pending is full, waitrequest stays high for the whole cycle in which a return retires a read. It drops on the following cycle.
- Writes are also blocked by waitrequest.
- Memory contents are not reset and are X until written.

## Timing
- Read accepted at edge N: `slave_readdatavalid` = 1 and `slave_readdata` valid during the cycle after edge N+READ_LATENCY-1. This means exactly READ_LATENCY cycles after the request cycle.
- Back-to-back accepted reads return back-to-back, in order, with no gaps and no reordering.
- Throughput: with MAX_PENDING < READ_LATENCY, sustained reads are throttled to MAX_PENDING accepts per READ_LATENCY+1 cycles.
- Write latency: zero wait states when waitrequest is low. A write is visible to any read accepted on a later edge.
- Reset values: `slave_readdatavalid` 0, `slave_readdata` 32'h0, `slave_waitrequest` 0 (stall logic reset as below), `protocol_err` 0, pending 0, delay line cleared.
- Reset during in-flight reads: all are discarded, and no `slave_readdatavalid` pulse follows the reset cycle.
- `slave_readdata` holds its last value while valid is low.

## Configuration
- `AVALON_PIXEL_SLAVE_STALL_EN`, when defined:
  - `stall` comes from an 8-bit Fibonacci LFSR with taps 8,6,5,4, reset to 8'hA5, advancing every cycle.
  - `stall = (lfsr[1:0] == 2'b00)`, so roughly 25% random wait states are inserted to stress master handshake logic.
- Undefined: `stall` is tied to 0, no LFSR is present, and waitrequest depends only on pending.

## Test plan
- Write 32'h00_11_22_33 to address 5 with byteenable 4'hF, then read address 5 -> readdatavalid pulses exactly 3 cycles after the read request, readdata = 32'h00112233.
- Write 32'hFFFFFFFF to address 7, then write 32'h000000AA with byteenable 4'b0001, then read -> 32'hFFFFFFAA.
- Hold `slave_read` high for 6 cycles on addresses 0..5 with MAX_PENDING=2, READ_LATENCY=3 -> waitrequest high on cycles 2-3 and 6-7, 6 returns in address order, pending never exceeds 2.
- Assert read and write to address 9 together with data 32'h1234 -> no readdatavalid, `protocol_err` = 1 and stays 1, a later read of address 9 returns 32'h1234.
- Accept 2 reads, assert `rst` one cycle later for 1 cycle -> no readdatavalid ever follows, waitrequest = 0 and pending = 0 after reset.
- With `AVALON_PIXEL_SLAVE_STALL_EN` defined, random traffic of 1000 operations -> all reads return scoreboard-correct data in order, and observed waitrequest matches the LFSR model bit-exactly.
